fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 21 ++
 rtl/fifo_wr_arb.sv | 107 ++++++++++
 tb/tb_fifo_wr_arb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int unsigned N_REQ_DEFAULT     = 4;
    localparam int unsigned DW_DEFAULT        = 16;
    localparam int unsigned MAX_BURST_DEFAULT = 8;
    localparam int unsigned CNT_W             = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner
);

    logic [N_REQ-1:0] req_rot;
    logic [N_REQ-1:0] win_rot;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_rot = N_REQ'({req, req} >> ptr);
        win_rot = req_rot & (~req_rot + N_REQ'(1));
        winner  = N_REQ'(({win_rot, win_rot} << ptr) >> N_REQ);
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter granting bursts of FIFO writes to one of N_REQ requesters.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = N_REQ_DEFAULT,
    parameter int unsigned DW        = DW_DEFAULT,
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ-1:0]    req_last,
    output logic [N_REQ-1:0]    req_ready,
    input  logic                wfull,
    output logic                winc,
    output logic [DW-1:0]       wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic                busy
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d, pick;
    logic [PTR_W-1:0]   ptr_q, ptr_d, gnt_idx;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W:0]     cnt_inc;
    logic [DW-1:0]      gnt_data;
    logic               gnt_req, gnt_last, write, release_grant;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick)
    );

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                gnt_idx  = PTR_W'(i);
                gnt_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        gnt_req       = (state_q == GRANT) && |(gnt_q & req);
        gnt_last      = |(gnt_q & req_last);
        write         = gnt_req && !wfull;
        cnt_inc       = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
        // Last word and burst limit landing together still yield one release.
        release_grant = !gnt_req
                     || (write && (gnt_last || cnt_inc >= (CNT_W+1)'(MAX_BURST)));

        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (write) begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
                if (release_grant) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign winc      = write;
    assign wdata     = write ? gnt_data : '0;
    assign req_ready = gnt_q & req & {N_REQ{~wfull}};
    assign gnt       = gnt_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb (N_REQ=4, DW=16, MAX_BURST=8).
module tb_fifo_wr_arb;

    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] req_data = 64'hA003_A002_A001_A000;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        wfull = 1'b0;
    logic        winc;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 wclk = ~wclk;

    fifo_wr_arb #(
        .N_REQ     (4),
        .DW        (16),
        .MAX_BURST (8)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .gnt       (gnt),
        .busy      (busy)
    );

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst = 1'b1; req = '0; req_last = '0; wfull = 1'b0;
        step();
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        wrst = 1'b1; req = 4'b1111; req_last = '0; wfull = 1'b0;
        step(); step(); #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (winc !== 1'b0) begin n_bad++; $display("FAIL reset_winc: got %b want 0", winc); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_cmp++; if (wdata !== 16'h0000) begin n_bad++; $display("FAIL reset_wdata: got %h want 0000", wdata); end
        wrst = 1'b0; req = '0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; #1;
        n_cmp++; if (gnt !== 4'b0000 || winc !== 1'b0 || req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL single_idle: got gnt=%b winc=%b rdy=%b want 0000/0/0000", gnt, winc, req_ready);
        end
        step();
        for (int b = 1; b <= 3; b++) begin
            req_last = (b == 3) ? 4'b0001 : 4'b0000; #1;
            n_cmp++; if (gnt !== 4'b0001 || winc !== 1'b1 || wdata !== 16'hA000) begin
                n_bad++; $display("FAIL single_beat%0d: got gnt=%b winc=%b wdata=%h want 0001/1/a000", b, gnt, winc, wdata);
            end
            step();
        end
        req_last = '0; req = 4'b0011; #1;
        n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_bad++; $display("FAIL single_release: got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
        step();
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL single_ptr: got %b want 0010", gnt); end
        req = '0; #1;
        n_cmp++; if (winc !== 1'b0) begin n_bad++; $display("FAIL single_drop_winc: got %b want 0", winc); end
        step();
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_g;
        logic [15:0] exp_d;
        int wrongs;
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << order[g];
            exp_d = 16'hA000 + 16'(order[g]);
            #1;
            n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0 || winc !== 1'b0) begin
                n_bad++; $display("FAIL rr_bubble%0d: got gnt=%b busy=%b winc=%b want 0000/0/0", g, gnt, busy, winc);
            end
            step();
            wrongs = 0;
            for (int b = 0; b < 8; b++) begin
                #1;
                if (gnt !== exp_g || winc !== 1'b1 || req_ready !== exp_g || wdata !== exp_d) wrongs++;
                step();
            end
            n_cmp++; if (wrongs !== 0) begin
                n_bad++; $display("FAIL rr_grant%0d: got %0d bad beats (last gnt=%b wdata=%h) want 0 for gnt=%b", g, wrongs, gnt, wdata, exp_g);
            end
        end
        req = '0; #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rr_end: got %b want 0000", gnt); end
        step();
    endtask

    task automatic test_wfull();
        int beats = 0;
        int wrongs = 0;
        do_reset();
        req = 4'b0100;
        step();
        for (int c = 0; c < 13; c++) begin
            wfull = (c >= 3 && c < 8); #1;
            if (gnt !== 4'b0100) wrongs++;
            if (wfull && (winc !== 1'b0 || req_ready !== 4'b0000 || wdata !== 16'h0000)) wrongs++;
            if (!wfull && (winc !== 1'b1 || wdata !== 16'hA002)) wrongs++;
            if (winc === 1'b1) beats++;
            step();
        end
        wfull = 1'b0; #1;
        n_cmp++; if (wrongs !== 0) begin n_bad++; $display("FAIL wfull_hold: got %0d bad cycles want 0", wrongs); end
        n_cmp++; if (beats !== 8) begin n_bad++; $display("FAIL wfull_total: got %0d beats want 8", beats); end
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL wfull_release: got %b want 0000", gnt); end
        req = '0;
        step();
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 4'b0010;
        step();
        req = 4'b0011; #1;
        n_cmp++; if (gnt !== 4'b0010 || winc !== 1'b1 || wdata !== 16'hA001) begin
            n_bad++; $display("FAIL drop_beat1: got gnt=%b winc=%b wdata=%h want 0010/1/a001", gnt, winc, wdata);
        end
        step();
        req = 4'b1010; #1;
        n_cmp++; if (gnt !== 4'b0010 || winc !== 1'b1) begin
            n_bad++; $display("FAIL drop_beat2: got gnt=%b winc=%b want 0010/1", gnt, winc);
        end
        step();
        req = 4'b1000; #1;
        n_cmp++; if (gnt !== 4'b0010 || winc !== 1'b0) begin
            n_bad++; $display("FAIL drop_cycle: got gnt=%b winc=%b want 0010/0", gnt, winc);
        end
        step();
        req = 4'b1011; #1;
        n_cmp++; if (gnt !== 4'b0000 || winc !== 1'b0) begin
            n_bad++; $display("FAIL drop_idle: got gnt=%b winc=%b want 0000/0", gnt, winc);
        end
        step();
        n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL drop_ptr: got %b want 1000", gnt); end
        req = '0;
        step();
    endtask

    task automatic test_last_burst();
        int wrongs = 0;
        do_reset();
        req = 4'b0001;
        step();
        for (int b = 1; b <= 8; b++) begin
            req_last = (b == 8) ? 4'b0001 : 4'b0000; #1;
            if (gnt !== 4'b0001 || winc !== 1'b1) wrongs++;
            step();
        end
        req_last = '0; req = 4'b0011; #1;
        n_cmp++; if (wrongs !== 0) begin n_bad++; $display("FAIL last8_beats: got %0d bad beats want 0", wrongs); end
        n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_bad++; $display("FAIL last8_bubble: got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
        step();
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL last8_next: got %b want 0010", gnt); end
        req = 4'b0010;
        wrongs = 0;
        for (int b = 0; b < 8; b++) begin
            #1;
            if (gnt !== 4'b0010 || winc !== 1'b1) wrongs++;
            step();
        end
        n_cmp++; if (wrongs !== 0 || gnt !== 4'b0000) begin
            n_bad++; $display("FAIL sole_bubble: got %0d bad beats gnt=%b want 0/0000", wrongs, gnt);
        end
        step();
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL sole_regrant: got %b want 0010", gnt); end
        req = '0;
        step(); step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        step();
        req = 4'b0000;
        step();
        req = 4'b1000;
        step();
        n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL rstmid_gnt3: got %b want 1000", gnt); end
        step(); step();
        req = 4'b1111; wrst = 1'b1;
        step();
        n_cmp++; if (gnt !== 4'b0000 || winc !== 1'b0 || busy !== 1'b0 || wdata !== 16'h0000) begin
            n_bad++; $display("FAIL rstmid_abort: got gnt=%b winc=%b busy=%b wdata=%h want 0000/0/0/0000", gnt, winc, busy, wdata);
        end
        wrst = 1'b0; #1;
        n_cmp++; if (gnt !== 4'b0000 || winc !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_idle: got gnt=%b winc=%b want 0000/0", gnt, winc);
        end
        step();
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rstmid_ptr0: got %b want 0001", gnt); end
        req = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wfull();
        test_req_drop();
        test_last_burst();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
